// File: rtl/rice_core_operand_fetch.sv
// Operand fetch stage: reads rs1/rs2 from the register file, tracks in-flight
// writes per register to stall on RAW hazards, and bypasses same-cycle writebacks.
module rice_core_operand_fetch #(
   parameter int XLEN          = 32,
   parameter int PAYLOAD_WIDTH = 64,
   parameter int MAX_INFLIGHT  = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_flush,
   input  logic                     i_id_valid,
   output logic                     o_id_ready,
   input  logic [4:0]               i_id_rs1,
   input  logic [4:0]               i_id_rs2,
   input  logic                     i_id_rs1_used,
   input  logic                     i_id_rs2_used,
   input  logic [4:0]               i_id_rd,
   input  logic [PAYLOAD_WIDTH-1:0] i_id_payload,
   input  logic [32*XLEN-1:0]       i_register_file,
   input  logic                     i_wb_valid,
   input  logic [4:0]               i_wb_rd,
   input  logic [XLEN-1:0]          i_wb_value,
   input  logic                     i_wb_error,
   output logic                     o_ex_valid,
   input  logic                     i_ex_ready,
   output logic [XLEN-1:0]          o_ex_rs1_value,
   output logic [XLEN-1:0]          o_ex_rs2_value,
   output logic [4:0]               o_ex_rd,
   output logic [PAYLOAD_WIDTH-1:0] o_ex_payload
);

   localparam int PW = $clog2(MAX_INFLIGHT + 1);

   // Handshake: a transfer happens on a side in any cycle where valid && ready;
   // valid never waits on ready, and the EX-side data holds while valid && !ready.

   logic [PW-1:0]   pend [32];
   logic [PW-1:0]   inflight;
   logic [PW-1:0]   inflight_eff;
   logic [XLEN-1:0] rf [32];
   logic [PW-1:0]   eff1, eff2;
   logic            wb_hit1, wb_hit2;
   logic            hazard;
   logic            accept;
   logic [XLEN-1:0] rs1_val, rs2_val;
   logic [31:0]     pend_inc, pend_dec;

   always_comb begin
      for (int i = 0; i < 32; i++) rf[i] = i_register_file[i*XLEN +: XLEN];
   end

   always_comb begin
      wb_hit1      = i_wb_valid && (i_wb_rd == i_id_rs1) && (i_id_rs1 != 5'd0);
      wb_hit2      = i_wb_valid && (i_wb_rd == i_id_rs2) && (i_id_rs2 != 5'd0);
      eff1         = pend[i_id_rs1] - PW'(wb_hit1);
      eff2         = pend[i_id_rs2] - PW'(wb_hit2);
      hazard       = (i_id_rs1_used && (eff1 != '0)) || (i_id_rs2_used && (eff2 != '0));
      inflight_eff = inflight - PW'(i_wb_valid);
      o_id_ready   = (!o_ex_valid || i_ex_ready) && !hazard &&
                     (inflight_eff < PW'(MAX_INFLIGHT)) && !i_flush;
      accept       = i_id_valid && o_id_ready;
   end

   // A faulted writeback still retires but never provides a bypass value.
   always_comb begin
      rs1_val = '0;
      rs2_val = '0;
      if (i_id_rs1_used && (i_id_rs1 != 5'd0))
         rs1_val = (wb_hit1 && !i_wb_error) ? i_wb_value : rf[i_id_rs1];
      if (i_id_rs2_used && (i_id_rs2 != 5'd0))
         rs2_val = (wb_hit2 && !i_wb_error) ? i_wb_value : rf[i_id_rs2];
   end

   always_comb begin
      for (int r = 0; r < 32; r++) begin
         pend_inc[r] = accept && (i_id_rd == 5'(r)) && (r != 0);
         pend_dec[r] = i_wb_valid && (i_wb_rd == 5'(r)) && (r != 0);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int r = 0; r < 32; r++) pend[r] <= '0;
         inflight       <= '0;
         o_ex_valid     <= 1'b0;
         o_ex_rs1_value <= '0;
         o_ex_rs2_value <= '0;
         o_ex_rd        <= '0;
         o_ex_payload   <= '0;
      end else if (i_flush) begin
         for (int r = 0; r < 32; r++) pend[r] <= '0;
         inflight   <= '0;
         o_ex_valid <= 1'b0;
      end else begin
         for (int r = 0; r < 32; r++)
            pend[r] <= pend[r] + PW'(pend_inc[r]) - PW'(pend_dec[r]);
         inflight <= inflight + PW'(accept) - PW'(i_wb_valid);
         if (accept) begin
            o_ex_valid     <= 1'b1;
            o_ex_rs1_value <= rs1_val;
            o_ex_rs2_value <= rs2_val;
            o_ex_rd        <= i_id_rd;
            o_ex_payload   <= i_id_payload;
         end else if (i_ex_ready) begin
            o_ex_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rice_core_operand_fetch.sv
// Directed bench for rice_core_operand_fetch: a per-register pending-count model
// with an expected-output queue, checked every cycle, plus literal checkpoints.
module tb_rice_core_operand_fetch;

   localparam int XLEN = 32;
   localparam int PL   = 64;
   localparam int MAXI = 4;
   localparam int W    = 5 + PL + 2*XLEN;

   logic            clk = 1'b0;
   logic            rst, flush;
   logic            id_valid, id_ready;
   logic [4:0]      id_rs1, id_rs2, id_rd;
   logic            rs1_used, rs2_used;
   logic [PL-1:0]   id_payload;
   logic [32*XLEN-1:0] reg_file;
   logic            wb_valid, wb_error;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_value;
   logic            ex_valid, ex_ready;
   logic [XLEN-1:0] ex_rs1, ex_rs2;
   logic [4:0]      ex_rd;
   logic [PL-1:0]   ex_payload;

   logic [XLEN-1:0] rf [32];
   int              m_pend [32];
   int              m_inflight;
   logic [W-1:0]    exp_q [$];
   int              checks = 0;
   int              passed = 0;

   rice_core_operand_fetch #(.XLEN(XLEN), .PAYLOAD_WIDTH(PL), .MAX_INFLIGHT(MAXI)) dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush),
      .i_id_valid(id_valid), .o_id_ready(id_ready),
      .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
      .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
      .i_id_rd(id_rd), .i_id_payload(id_payload),
      .i_register_file(reg_file),
      .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_wb_value(wb_value), .i_wb_error(wb_error),
      .o_ex_valid(ex_valid), .i_ex_ready(ex_ready),
      .o_ex_rs1_value(ex_rs1), .o_ex_rs2_value(ex_rs2),
      .o_ex_rd(ex_rd), .o_ex_payload(ex_payload)
   );

   // ---------------- clock / register file image ----------------
   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 32; i++) reg_file[i*XLEN +: XLEN] = rf[i];
   end

   // ---------------- model ----------------
   function automatic logic [XLEN-1:0] m_operand(input logic [4:0] s, input logic used);
      if (!used || s == 5'd0) return '0;
      if (wb_valid && !wb_error && wb_rd == s) return wb_value;
      return rf[s];
   endfunction

   function automatic bit m_busy(input logic [4:0] s, input logic used);
      int left;
      if (!used) return 1'b0;
      left = m_pend[s] - ((wb_valid && wb_rd == s && s != 5'd0) ? 1 : 0);
      return left != 0;
   endfunction

   function automatic bit m_ready();
      int room;
      room = m_inflight - (wb_valid ? 1 : 0);
      return (exp_q.size() == 0 || ex_ready) && !m_busy(id_rs1, rs1_used) &&
             !m_busy(id_rs2, rs2_used) && (room < MAXI) && !flush;
   endfunction

   always @(posedge clk) begin
      bit           acc;
      logic [W-1:0] entry;
      if (rst) begin
         for (int r = 0; r < 32; r++) m_pend[r] = 0;
         m_inflight = 0;
         exp_q.delete();
      end else if (flush) begin
         for (int r = 0; r < 32; r++) m_pend[r] = 0;
         m_inflight = 0;
         exp_q.delete();
      end else begin
         acc   = id_valid && m_ready();
         entry = {id_rd, id_payload, m_operand(id_rs1, rs1_used), m_operand(id_rs2, rs2_used)};
         if (wb_valid) begin
            assert (m_inflight > 0) else $error("writeback with nothing in flight");
            m_inflight--;
            if (wb_rd != 5'd0) begin
               assert (m_pend[wb_rd] > 0) else $error("writeback to r%0d with no pending write", wb_rd);
               m_pend[wb_rd]--;
            end
         end
         if (acc) begin
            m_inflight++;
            if (id_rd != 5'd0) m_pend[id_rd]++;
         end
         assert (m_inflight <= MAXI) else $error("inflight above limit");
         if (exp_q.size() != 0 && ex_ready) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(entry);
      end
   end

   // ---------------- scoreboard compare ----------------
   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("id_ready", W'(id_ready), W'(m_ready()));
         check("ex_valid", W'(ex_valid), W'(exp_q.size() != 0));
         if (ex_valid && exp_q.size() != 0)
            check("ex_data", {ex_rd, ex_payload, ex_rs1, ex_rs2}, exp_q[0]);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] s1, input logic u1, input logic [4:0] s2,
                        input logic u2, input logic [4:0] rd, input logic [PL-1:0] pl);
      id_valid = 1'b1; id_rs1 = s1; rs1_used = u1; id_rs2 = s2; rs2_used = u2;
      id_rd = rd; id_payload = pl;
   endtask

   task automatic idle_id();
      id_valid = 1'b0; rs1_used = 1'b0; rs2_used = 1'b0;
   endtask

   task automatic wb(input logic [4:0] rd, input logic [XLEN-1:0] v, input logic err);
      wb_valid = 1'b1; wb_rd = rd; wb_value = v; wb_error = err;
   endtask

   task automatic no_wb();
      wb_valid = 1'b0; wb_error = 1'b0;
   endtask

   task automatic check_ready_now(input string name, input logic exp);
      #1;
      check(name, W'(id_ready), W'(exp));
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int total_pend;
      for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
      rf[0] = 32'hDEAD; rf[5] = 32'h11; rf[6] = 32'h22;
      rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
      id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_payload = '0;
      wb_rd = '0; wb_value = '0;
      idle_id(); no_wb();
      tick(); tick();
      check("reset_ex_valid", W'(ex_valid), '0);
      check("reset_ex_data", {ex_rd, ex_payload, ex_rs1, ex_rs2}, '0);
      rst = 1'b0;

      // basic read, then index-0 and unused-source reads with a retire alongside
      issue(5'd5, 1'b1, 5'd6, 1'b1, 5'd1, 64'hA1);
      check_ready_now("t1_ready", 1'b1);
      tick();
      check("t1_valid", W'(ex_valid), W'(1));
      check("t1_rs1", W'(ex_rs1), W'(32'h11));
      check("t1_rs2", W'(ex_rs2), W'(32'h22));
      check("t1_pend1", W'(m_pend[1]), W'(1));
      issue(5'd0, 1'b1, 5'd6, 1'b0, 5'd0, 64'hB2);
      wb(5'd1, 32'h5555, 1'b0);
      tick();
      check("t1_zero_ops", {ex_rs1, ex_rs2}, '0);
      idle_id(); wb(5'd0, 32'h0, 1'b0);
      tick();
      no_wb();

      // RAW stall on r3, released by a bypassed writeback
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 64'hC3);
      tick();
      issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd8, 64'hC4);
      check_ready_now("t2_stall", 1'b0);
      tick(); tick();
      wb(5'd3, 32'hABCD, 1'b0);
      check_ready_now("t2_release", 1'b1);
      tick();
      check("t2_bypass", W'(ex_rs1), W'(32'hABCD));
      check("t2_pend3", W'(m_pend[3]), W'(0));
      idle_id(); wb(5'd8, 32'h88, 1'b0);
      tick();
      no_wb();

      // two writers to r7, reader waits for the second
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 64'hD1);
      tick();
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 64'hD2);
      tick();
      issue(5'd0, 1'b0, 5'd7, 1'b1, 5'd9, 64'hD3);
      check_ready_now("t3_stall", 1'b0);
      tick();
      wb(5'd7, 32'h111, 1'b0);
      check_ready_now("t3_first_wb", 1'b0);
      tick();
      wb(5'd7, 32'h222, 1'b0);
      check_ready_now("t3_second_wb", 1'b1);
      tick();
      check("t3_rs2", W'(ex_rs2), W'(32'h222));
      idle_id(); wb(5'd9, 32'h99, 1'b0);
      tick();
      no_wb();

      // faulted writeback releases the reader but is not bypassed
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 64'hE1);
      tick();
      issue(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 64'hE2);
      tick();
      wb(5'd4, 32'hBAD, 1'b1);
      check_ready_now("t4_release", 1'b1);
      tick();
      check("t4_no_bypass", W'(ex_rs1), W'(32'h1004));
      check("t4_pend4", W'(m_pend[4]), W'(0));
      idle_id(); wb(5'd0, 32'h0, 1'b0);
      tick();
      no_wb();

      // inflight limit
      for (int k = 0; k < 4; k++) begin
         issue(5'd0, 1'b0, 5'd0, 1'b0, 5'(10 + k), 64'hF0 + 64'(k));
         tick();
      end
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 64'hF4);
      check_ready_now("t5_full", 1'b0);
      tick();
      wb(5'd0, 32'h0, 1'b0);
      check_ready_now("t5_room", 1'b1);
      tick();
      check("t5_rd", W'(ex_rd), W'(14));
      idle_id(); no_wb();

      // EX backpressure, then flush clears everything
      ex_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check_ready_now("t6_hold_ready", 1'b0);
         tick();
         check("t6_hold_data", {ex_valid, ex_rd, ex_payload}, {1'b1, 5'd14, 64'hF4});
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("t6_flush_valid", W'(ex_valid), '0);
      total_pend = 0;
      for (int r = 0; r < 32; r++) total_pend += m_pend[r];
      check("t6_model_clear", W'(total_pend + m_inflight), '0);
      ex_ready = 1'b1;
      issue(5'd10, 1'b1, 5'd0, 1'b0, 5'd2, 64'hAA);
      check_ready_now("t6_after_flush", 1'b1);
      tick();
      check("t6_rs1", W'(ex_rs1), W'(32'h100A));
      idle_id(); wb(5'd2, 32'h22, 1'b0);
      tick();
      no_wb();

      // reset while an instruction is stalled behind a held output
      ex_ready = 1'b0;
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd15, 64'h15);
      tick();
      issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd16, 64'h16);
      tick();
      rst = 1'b1;
      tick();
      check("t7_reset_valid", W'(ex_valid), '0);
      idle_id(); ex_ready = 1'b1;
      tick();
      rst = 1'b0;
      tick(); tick();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/rice_core_operand_fetch.md
Name: rice_core_operand_fetch

Overview:
- Read side of the integer register file: the ID/EX boundary stage that reads rs1/rs2 operands for a decoded instruction and forwards them to EX.
- Keeps a per-register scoreboard of in-flight writes and stalls on RAW hazards.
- Bypasses a same-cycle writeback, because the register file write only becomes visible one cycle later.
- Register stage with a valid/ready handshake on both sides.

Parameters:
- XLEN, 32, operand/register width.
- PAYLOAD_WIDTH, 64, opaque decoded-instruction bits carried to EX unchanged.
- MAX_INFLIGHT, 4, maximum issued-but-not-written-back instructions; range 1..15.

Ports:
- i_clk  input  1  clock
- i_rst  input  1  reset; synchronous, active-high
- i_flush  input  1  pipeline flush
- i_id_valid  input  1  decoded instruction valid
- o_id_ready  output  1  stage accepts instruction
- i_id_rs1  input  5  source 1 index
- i_id_rs2  input  5  source 2 index
- i_id_rs1_used  input  1  rs1 is read
- i_id_rs2_used  input  1  rs2 is read
- i_id_rd  input  5  destination index
- i_id_payload  input  PAYLOAD_WIDTH  opaque payload
- i_register_file  input  32*XLEN  register file contents; entry i at bits [i*XLEN +: XLEN]; entry 0 reads zero
- i_wb_valid  input  1  writeback/retire pulse, exactly one per issued instruction
- i_wb_rd  input  5  writeback destination
- i_wb_value  input  XLEN  writeback value
- i_wb_error  input  1  instruction faulted; no register write
- o_ex_valid  output  1  operands valid to EX
- i_ex_ready  input  1  EX accepts
- o_ex_rs1_value  output  XLEN  operand 1
- o_ex_rs2_value  output  XLEN  operand 2
- o_ex_rd  output  5  destination index
- o_ex_payload  output  PAYLOAD_WIDTH  payload

Behaviour:
- **Reset.** o_ex_valid=0; all other outputs 0; scoreboard counters 0; inflight counter 0.
- **Scoreboard counters.** pend[r] has width clog2(MAX_INFLIGHT+1).
  - accept (i_id_valid && o_id_ready) with rd!=0: pend[rd]+1.
  - i_wb_valid with rd!=0: pend[wb_rd]-1. This applies whether or not i_wb_error is set.
  - Accept and writeback on the same rd in the same cycle: no change.
  - pend[0] is always 0.
- **Inflight counter.** Increments on each accept and decrements on each i_wb_valid; simultaneous events leave it unchanged.
- **Effective pending.** eff[r] = pend[r] − (i_wb_valid && i_wb_rd==r && r!=0).
- **Hazard.** hazard = (rs1_used && eff[rs1]!=0) || (rs2_used && eff[rs2]!=0).
- **Ready.** o_id_ready = (!o_ex_valid || i_ex_ready) && !hazard && (inflight_eff < MAX_INFLIGHT) && !i_flush.
  - inflight_eff is the inflight counter minus the current-cycle writeback.
- **Operand selection.** For each used source register s:
  - if i_wb_valid && !i_wb_error && i_wb_rd==s && s!=0, take i_wb_value (bypass);
  - otherwise take i_register_file[s].
  - Index 0 always yields 0. An unused source yields 0.
- **Latency.** One cycle from accept to o_ex_valid. Fully pipelined: back-to-back accepts are allowed when EX is ready.
- **Output register.**
  - On accept: load operands, rd and payload; set o_ex_valid=1.
  - Else if i_ex_ready: clear o_ex_valid.
  - Output data holds stable while o_ex_valid && !i_ex_ready.
- **Flush.** When i_flush is asserted:
  - o_ex_valid clears next cycle;
  - all pend[] and the inflight counter clear to 0;
  - no accept occurs that cycle.
  - EX/WB discard all older in-flight instructions on flush, so no writeback for them arrives afterwards.
  - Flush has priority over accept and writeback.
- **Reset priority.** Reset has priority over flush. Reset mid-stall drops the held instruction.
- **Saturation.** Counters never wrap. Inflight is bounded by MAX_INFLIGHT and pend[r] ≤ inflight. A writeback arriving when its counter is 0 is a protocol violation; the bench checks it by assertion.

Test Plan:
- Reset then issue "rs1=5, rs2=6" with RF[5]=0x11, RF[6]=0x22, EX ready → o_ex_valid next cycle, operands 0x11/0x22, pend[rd] becomes 1.
- Issue rd=3, then rs1=3 with no writeback → o_id_ready=0 until wb(rd=3, value 0xABCD) arrives. In that wb cycle: accepted, bypassed rs1 value 0xABCD, pend[3]=0.
- Two in flight to rd=7, then a reader of r7 → stalls through the first wb and is accepted in the second wb cycle with the second wb's value.
- wb(rd=4, error=1) while reader of r4 is waiting → reader is accepted with i_register_file[4] (no bypass), pend[4]=0.
- MAX_INFLIGHT=4: four independent issues with no wb → fifth stalls. A single wb with no rd (rd=0) → fifth accepted that cycle.
- o_ex_valid held with i_ex_ready=0 for 3 cycles → outputs stable, o_id_ready=0. Then i_flush → o_ex_valid=0 next cycle, scoreboard all zero, and an immediate reader of a previously pending rd is accepted.
